lsu_mem_arbiter: RTL and testbench

- Shares NUM_CHANNELS data-memory ports between NUM_CONSUMERS LSU request ports (one per thread lane).
- Sits between the per-thread LSUs and the external data memory interface.
- Each channel runs an independent FSM that claims one pending LSU request, forwards it to memory, then relays the response back.
- Fair round-robin selection per channel. A consumer is served by at most one channel at a time.

---
 rtl/lsu_mem_arbiter_pkg.sv | 16 +
 rtl/lsu_mem_arbiter_rr_picker.sv | 30 +++
 rtl/lsu_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU-to-data-memory arbiter: data/address widths and
// the per-channel FSM state encoding.
package lsu_mem_arbiter_pkg;

   typedef logic [7:0] data_t;
   typedef logic [7:0] data_memory_address_t;

   typedef logic [2:0] channel_state_t;

   localparam channel_state_t CH_IDLE        = 3'd0;
   localparam channel_state_t CH_READ_WAIT   = 3'd1;
   localparam channel_state_t CH_WRITE_WAIT  = 3'd2;
   localparam channel_state_t CH_READ_RELAY  = 3'd3;
   localparam channel_state_t CH_WRITE_RELAY = 3'd4;

endpackage

// File: rtl/lsu_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// after the start index, wrapping modulo N.
module lsu_mem_arbiter_rr_picker
   import lsu_mem_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] grant,
   output logic         found
);

   logic [W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(start) + i >= N) ? W'(int'(start) + i - N) : W'(int'(start) + i);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares NUM_CHANNELS data-memory ports among NUM_CONSUMERS LSU ports; each
// channel claims one request round-robin, forwards it, and relays the reply.
module lsu_mem_arbiter
   import lsu_mem_arbiter_pkg::*;
#(
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CONSUMERS-1:0]  consumer_read_valid,
   input  data_memory_address_t      consumer_read_address [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0]  consumer_read_ready,
   output data_t                     consumer_read_data [NUM_CONSUMERS],
   input  logic [NUM_CONSUMERS-1:0]  consumer_write_valid,
   input  data_memory_address_t      consumer_write_address [NUM_CONSUMERS],
   input  data_t                     consumer_write_data [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0]  consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]   mem_read_valid,
   output data_memory_address_t      mem_read_address [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0]   mem_read_ready,
   input  data_t                     mem_read_data [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0]   mem_write_valid,
   output data_memory_address_t      mem_write_address [NUM_CHANNELS],
   output data_t                     mem_write_data [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0]   mem_write_ready,
   output channel_state_t            channel_state [NUM_CHANNELS]
);

   // Handshake: a consumer holds valid (and its payload) until it sees ready;
   // ready is then held until the consumer drops valid, which frees the channel.
   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_CONSUMERS - 1);

   channel_state_t           state   [NUM_CHANNELS];
   logic [CW-1:0]            current [NUM_CHANNELS];
   logic [CW-1:0]            rr_ptr  [NUM_CHANNELS];
   logic [CW-1:0]            grant   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  take;
   logic [NUM_CONSUMERS-1:0] busy;
   logic [NUM_CONSUMERS-1:0] pending;

   assign pending = (consumer_read_valid | consumer_write_valid) & ~busy;

   // Lower channels pick first; their claims are masked out for higher ones.
   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
      logic [NUM_CONSUMERS-1:0] claimed_in;
      logic [NUM_CONSUMERS-1:0] avail;
      logic [CW-1:0]            pick;
      logic                     hit;
      logic                     idle_hit;

      if (ch == 0) begin : g_first
         assign claimed_in = '0;
      end else begin : g_next
         assign claimed_in = g_ch[ch-1].claimed_in |
            (g_ch[ch-1].idle_hit ? (NUM_CONSUMERS'(1) << g_ch[ch-1].pick) : '0);
      end

      assign avail = pending & ~claimed_in;

      lsu_mem_arbiter_rr_picker #(
         .N (NUM_CONSUMERS),
         .W (CW)
      ) u_picker (
         .req   (avail),
         .start (rr_ptr[ch]),
         .grant (pick),
         .found (hit)
      );

      assign idle_hit          = (state[ch] == CH_IDLE) && hit;
      assign take[ch]          = idle_hit;
      assign grant[ch]         = pick;
      assign channel_state[ch] = state[ch];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy                 <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         mem_read_valid       <= '0;
         mem_write_valid      <= '0;
         for (int c = 0; c < NUM_CONSUMERS; c++) begin
            consumer_read_data[c] <= '0;
         end
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state[ch]             <= CH_IDLE;
            current[ch]           <= '0;
            rr_ptr[ch]            <= '0;
            mem_read_address[ch]  <= '0;
            mem_write_address[ch] <= '0;
            mem_write_data[ch]    <= '0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state[ch])
               CH_IDLE: begin
                  if (take[ch]) begin
                     busy[grant[ch]] <= 1'b1;
                     current[ch]     <= grant[ch];
                     rr_ptr[ch]      <= (grant[ch] == LAST) ? '0 : grant[ch] + 1'b1;
                     // A consumer asserting both valids gets its read served.
                     if (consumer_read_valid[grant[ch]]) begin
                        mem_read_valid[ch]   <= 1'b1;
                        mem_read_address[ch] <= consumer_read_address[grant[ch]];
                        state[ch]            <= CH_READ_WAIT;
                     end else begin
                        mem_write_valid[ch]   <= 1'b1;
                        mem_write_address[ch] <= consumer_write_address[grant[ch]];
                        mem_write_data[ch]    <= consumer_write_data[grant[ch]];
                        state[ch]             <= CH_WRITE_WAIT;
                     end
                  end
               end
               CH_READ_WAIT: begin
                  if (mem_read_ready[ch]) begin
                     mem_read_valid[ch]                  <= 1'b0;
                     consumer_read_data[current[ch]]     <= mem_read_data[ch];
                     consumer_read_ready[current[ch]]    <= 1'b1;
                     state[ch]                           <= CH_READ_RELAY;
                  end
               end
               CH_WRITE_WAIT: begin
                  if (mem_write_ready[ch]) begin
                     mem_write_valid[ch]               <= 1'b0;
                     consumer_write_ready[current[ch]] <= 1'b1;
                     state[ch]                         <= CH_WRITE_RELAY;
                  end
               end
               CH_READ_RELAY: begin
                  if (!consumer_read_valid[current[ch]]) begin
                     consumer_read_ready[current[ch]] <= 1'b0;
                     busy[current[ch]]                <= 1'b0;
                     state[ch]                        <= CH_IDLE;
                  end
               end
               CH_WRITE_RELAY: begin
                  if (!consumer_write_valid[current[ch]]) begin
                     consumer_write_ready[current[ch]] <= 1'b0;
                     busy[current[ch]]                 <= 1'b0;
                     state[ch]                         <= CH_IDLE;
                  end
               end
               default: state[ch] <= CH_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: a single-channel and a two-channel
// instance share the consumer-side stimulus; memory sides are driven separately.
module tb_lsu_mem_arbiter;
   import lsu_mem_arbiter_pkg::*;

   logic clk;
   logic reset;
   logic [3:0] rd_valid, wr_valid;
   data_memory_address_t rd_addr [4];
   data_memory_address_t wr_addr [4];
   data_t wr_data [4];

   logic [3:0] a_rd_ready, a_wr_ready;
   data_t a_rd_data [4];
   logic [0:0] a_mrv, a_mrr, a_mwv, a_mwr;
   data_memory_address_t a_mra [1];
   data_memory_address_t a_mwa [1];
   data_t a_mrd [1];
   data_t a_mwd [1];
   channel_state_t a_state [1];

   logic [3:0] b_rd_ready, b_wr_ready;
   data_t b_rd_data [4];
   logic [1:0] b_mrv, b_mrr, b_mwv, b_mwr;
   data_memory_address_t b_mra [2];
   data_memory_address_t b_mwa [2];
   data_t b_mrd [2];
   data_t b_mwd [2];
   channel_state_t b_state [2];

   int checks;
   int passed;

   lsu_mem_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut_one (
      .clk(clk), .reset(reset),
      .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
      .consumer_read_ready(a_rd_ready), .consumer_read_data(a_rd_data),
      .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
      .consumer_write_data(wr_data), .consumer_write_ready(a_wr_ready),
      .mem_read_valid(a_mrv), .mem_read_address(a_mra),
      .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
      .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
      .mem_write_data(a_mwd), .mem_write_ready(a_mwr),
      .channel_state(a_state)
   );

   lsu_mem_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut_two (
      .clk(clk), .reset(reset),
      .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
      .consumer_read_ready(b_rd_ready), .consumer_read_data(b_rd_data),
      .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
      .consumer_write_data(wr_data), .consumer_write_ready(b_wr_ready),
      .mem_read_valid(b_mrv), .mem_read_address(b_mra),
      .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
      .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
      .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
      .channel_state(b_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic apply_reset();
      reset = 1'b0;
      rd_valid = '0;
      wr_valid = '0;
      a_mrr = '0; a_mwr = '0; b_mrr = '0; b_mwr = '0;
      a_mrd[0] = '0; b_mrd[0] = '0; b_mrd[1] = '0;
      for (int i = 0; i < 4; i++) begin
         rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      rd_valid = 4'hF;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (a_mrv !== 1'b0) $display("FAIL reset_a_mrv: got %b want 0", a_mrv); else passed++;
      checks++; if (a_mwv !== 1'b0) $display("FAIL reset_a_mwv: got %b want 0", a_mwv); else passed++;
      checks++; if (a_rd_ready !== 4'h0) $display("FAIL reset_a_rd_ready: got %b want 0000", a_rd_ready); else passed++;
      checks++; if (a_wr_ready !== 4'h0) $display("FAIL reset_a_wr_ready: got %b want 0000", a_wr_ready); else passed++;
      checks++; if (a_mra[0] !== 8'h00) $display("FAIL reset_a_mra: got %h want 00", a_mra[0]); else passed++;
      checks++; if (a_state[0] !== CH_IDLE) $display("FAIL reset_a_state: got %0d want %0d", a_state[0], CH_IDLE); else passed++;
      checks++; if (b_mrv !== 2'b00) $display("FAIL reset_b_mrv: got %b want 00", b_mrv); else passed++;
      checks++; if (b_mwv !== 2'b00) $display("FAIL reset_b_mwv: got %b want 00", b_mwv); else passed++;
      checks++; if (b_state[1] !== CH_IDLE) $display("FAIL reset_b_state1: got %0d want %0d", b_state[1], CH_IDLE); else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_rd_data[i] !== 8'h00) $display("FAIL reset_a_rd_data%0d: got %h want 00", i, a_rd_data[i]); else passed++;
      end
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      apply_reset();
      rd_addr[2] = 8'h10;
      rd_valid[2] = 1'b1;
      @(negedge clk);
      checks++; if (a_mrv !== 1'b1) $display("FAIL single_mrv: got %b want 1", a_mrv); else passed++;
      checks++; if (a_mra[0] !== 8'h10) $display("FAIL single_mra: got %h want 10", a_mra[0]); else passed++;
      checks++; if (a_state[0] !== CH_READ_WAIT) $display("FAIL single_state_wait: got %0d want %0d", a_state[0], CH_READ_WAIT); else passed++;
      repeat (2) @(negedge clk);
      checks++; if (a_mrv !== 1'b1) $display("FAIL single_mrv_held: got %b want 1", a_mrv); else passed++;
      checks++; if (a_rd_ready !== 4'h0) $display("FAIL single_ready_early: got %b want 0000", a_rd_ready); else passed++;
      a_mrr[0] = 1'b1;
      a_mrd[0] = 8'hAB;
      @(negedge clk);
      a_mrr[0] = 1'b0;
      a_mrd[0] = 8'h00;
      checks++; if (a_rd_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", a_rd_ready); else passed++;
      checks++; if (a_rd_data[2] !== 8'hAB) $display("FAIL single_data: got %h want ab", a_rd_data[2]); else passed++;
      checks++; if (a_mrv !== 1'b0) $display("FAIL single_mrv_drop: got %b want 0", a_mrv); else passed++;
      repeat (2) @(negedge clk);
      checks++; if (a_rd_ready !== 4'b0100) $display("FAIL single_ready_hold: got %b want 0100", a_rd_ready); else passed++;
      rd_valid[2] = 1'b0;
      @(negedge clk);
      checks++; if (a_rd_ready !== 4'h0) $display("FAIL single_ready_release: got %b want 0000", a_rd_ready); else passed++;
      checks++; if (a_state[0] !== CH_IDLE) $display("FAIL single_state_idle: got %0d want %0d", a_state[0], CH_IDLE); else passed++;
   endtask

   task automatic test_round_robin();
      int n;
      int e;
      apply_reset();
      for (int i = 0; i < 4; i++) rd_addr[i] = 8'h40 + 8'(i);
      rd_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         e = k % 4;
         n = 0;
         @(negedge clk);
         while (a_mrv !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         checks++; if (a_mrv !== 1'b1) $display("FAIL rr_wait%0d: got mrv %b want 1 within 20 cycles", k, a_mrv); else passed++;
         checks++; if (a_mra[0] !== 8'h40 + 8'(e)) $display("FAIL rr_order%0d: got addr %h want %h", k, a_mra[0], 8'h40 + 8'(e)); else passed++;
         a_mrr[0] = 1'b1;
         a_mrd[0] = 8'h90 + 8'(k);
         @(negedge clk);
         a_mrr[0] = 1'b0;
         checks++; if (a_rd_ready !== (4'b0001 << e)) $display("FAIL rr_ready%0d: got %b want %b", k, a_rd_ready, 4'b0001 << e); else passed++;
         checks++; if (a_rd_data[e] !== 8'h90 + 8'(k)) $display("FAIL rr_data%0d: got %h want %h", k, a_rd_data[e], 8'h90 + 8'(k)); else passed++;
         rd_valid[e] = 1'b0;
         @(negedge clk);
         checks++; if (a_rd_ready !== 4'h0) $display("FAIL rr_release%0d: got %b want 0000", k, a_rd_ready); else passed++;
         rd_valid[e] = 1'b1;
      end
      rd_valid = '0;
   endtask

   task automatic test_write();
      apply_reset();
      wr_addr[1] = 8'h22;
      wr_data[1] = 8'h5C;
      wr_valid[1] = 1'b1;
      @(negedge clk);
      checks++; if (a_mwv !== 1'b1) $display("FAIL write_mwv: got %b want 1", a_mwv); else passed++;
      checks++; if (a_mrv !== 1'b0) $display("FAIL write_no_read: got %b want 0", a_mrv); else passed++;
      checks++; if (a_mwa[0] !== 8'h22) $display("FAIL write_addr: got %h want 22", a_mwa[0]); else passed++;
      checks++; if (a_mwd[0] !== 8'h5C) $display("FAIL write_data: got %h want 5c", a_mwd[0]); else passed++;
      @(negedge clk);
      checks++; if (a_wr_ready !== 4'h0) $display("FAIL write_ready_early: got %b want 0000", a_wr_ready); else passed++;
      a_mwr[0] = 1'b1;
      @(negedge clk);
      a_mwr[0] = 1'b0;
      checks++; if (a_wr_ready !== 4'b0010) $display("FAIL write_ready: got %b want 0010", a_wr_ready); else passed++;
      checks++; if (a_mwv !== 1'b0) $display("FAIL write_mwv_drop: got %b want 0", a_mwv); else passed++;
      wr_valid[1] = 1'b0;
      @(negedge clk);
      checks++; if (a_wr_ready !== 4'h0) $display("FAIL write_release: got %b want 0000", a_wr_ready); else passed++;
      checks++; if (a_state[0] !== CH_IDLE) $display("FAIL write_idle: got %0d want %0d", a_state[0], CH_IDLE); else passed++;
   endtask

   task automatic test_two_channels();
      apply_reset();
      rd_addr[0] = 8'h30;
      rd_addr[3] = 8'h33;
      rd_valid = 4'b1001;
      @(negedge clk);
      checks++; if (b_mrv !== 2'b11) $display("FAIL two_mrv: got %b want 11", b_mrv); else passed++;
      checks++; if (b_mra[0] !== 8'h30) $display("FAIL two_ch0_addr: got %h want 30", b_mra[0]); else passed++;
      checks++; if (b_mra[1] !== 8'h33) $display("FAIL two_ch1_addr: got %h want 33", b_mra[1]); else passed++;
      b_mrr = 2'b11;
      b_mrd[0] = 8'h11;
      b_mrd[1] = 8'h22;
      @(negedge clk);
      b_mrr = 2'b00;
      checks++; if (b_rd_ready !== 4'b1001) $display("FAIL two_ready: got %b want 1001", b_rd_ready); else passed++;
      checks++; if (b_rd_data[0] !== 8'h11) $display("FAIL two_data0: got %h want 11", b_rd_data[0]); else passed++;
      checks++; if (b_rd_data[3] !== 8'h22) $display("FAIL two_data3: got %h want 22", b_rd_data[3]); else passed++;
      rd_valid = 4'b0000;
      @(negedge clk);
      checks++; if (b_rd_ready !== 4'h0) $display("FAIL two_release: got %b want 0000", b_rd_ready); else passed++;
      rd_addr[1] = 8'h31;
      rd_valid = 4'b0010;
      @(negedge clk);
      checks++; if (b_mrv !== 2'b01) $display("FAIL two_single_grant: got %b want 01", b_mrv); else passed++;
      checks++; if (b_mra[0] !== 8'h31) $display("FAIL two_single_addr: got %h want 31", b_mra[0]); else passed++;
      @(negedge clk);
      checks++; if (b_mrv !== 2'b01) $display("FAIL two_no_double: got %b want 01", b_mrv); else passed++;
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      rd_addr[2] = 8'h52;
      rd_addr[3] = 8'h53;
      rd_valid = 4'b1100;
      @(negedge clk);
      checks++; if (a_mra[0] !== 8'h52) $display("FAIL mid_first_grant: got %h want 52", a_mra[0]); else passed++;
      checks++; if (a_state[0] !== CH_READ_WAIT) $display("FAIL mid_state: got %0d want %0d", a_state[0], CH_READ_WAIT); else passed++;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (a_mrv !== 1'b0) $display("FAIL mid_async_a_mrv: got %b want 0", a_mrv); else passed++;
      checks++; if (b_mrv !== 2'b00) $display("FAIL mid_async_b_mrv: got %b want 00", b_mrv); else passed++;
      checks++; if (a_state[0] !== CH_IDLE) $display("FAIL mid_async_state: got %0d want %0d", a_state[0], CH_IDLE); else passed++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (a_mrv !== 1'b1) $display("FAIL mid_regrant_mrv: got %b want 1", a_mrv); else passed++;
      checks++; if (a_mra[0] !== 8'h52) $display("FAIL mid_regrant_addr: got %h want 52", a_mra[0]); else passed++;
      checks++; if (b_mra[0] !== 8'h52) $display("FAIL mid_regrant_b0: got %h want 52", b_mra[0]); else passed++;
      checks++; if (b_mra[1] !== 8'h53) $display("FAIL mid_regrant_b1: got %h want 53", b_mra[1]); else passed++;
   endtask

   task automatic test_conflict();
      apply_reset();
      rd_addr[0] = 8'h60;
      wr_addr[0] = 8'h61;
      wr_data[0] = 8'h77;
      rd_valid[0] = 1'b1;
      wr_valid[0] = 1'b1;
      @(negedge clk);
      checks++; if (a_mrv !== 1'b1) $display("FAIL conflict_mrv: got %b want 1", a_mrv); else passed++;
      checks++; if (a_mwv !== 1'b0) $display("FAIL conflict_mwv: got %b want 0", a_mwv); else passed++;
      checks++; if (a_mra[0] !== 8'h60) $display("FAIL conflict_addr: got %h want 60", a_mra[0]); else passed++;
      a_mrr[0] = 1'b1;
      a_mrd[0] = 8'h3C;
      @(negedge clk);
      a_mrr[0] = 1'b0;
      checks++; if (a_rd_ready !== 4'b0001) $display("FAIL conflict_rd_ready: got %b want 0001", a_rd_ready); else passed++;
      checks++; if (a_wr_ready !== 4'h0) $display("FAIL conflict_wr_ready: got %b want 0000", a_wr_ready); else passed++;
      rd_valid[0] = 1'b0;
      @(negedge clk);
      checks++; if (a_state[0] !== CH_IDLE) $display("FAIL conflict_idle: got %0d want %0d", a_state[0], CH_IDLE); else passed++;
      @(negedge clk);
      checks++; if (a_mwv !== 1'b1) $display("FAIL b2b_write_mwv: got %b want 1", a_mwv); else passed++;
      checks++; if (a_mwa[0] !== 8'h61) $display("FAIL b2b_write_addr: got %h want 61", a_mwa[0]); else passed++;
      checks++; if (a_mwd[0] !== 8'h77) $display("FAIL b2b_write_data: got %h want 77", a_mwd[0]); else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_two_channels();
      test_reset_mid_op();
      test_conflict();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
